// File: rtl/jtdd_gfx_romslot.sv
// Graphics ROM slot: serves layer fetches from a local tag/data store, fills misses over the SDRAM req/ack/dst/rdy handshake.
// Define JTDD_ROMSLOT_CACHE_EN for a two-entry store with a round-robin victim; otherwise a single entry.
module jtdd_gfx_romslot #(
    parameter int          AW     = 17,
    parameter int          DW     = 16,
    parameter logic [21:0] OFFSET = 22'h0
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [AW-1:0] addr,
    input  logic          addr_ok,
    input  logic          clr,
    output logic [DW-1:0] dout,
    output logic          ok,
    output logic [21:0]   sdram_addr,
    output logic          sdram_req,
    input  logic          sdram_ack,
    input  logic          data_dst,
    input  logic          data_rdy,
    input  logic [DW-1:0] data_read
);

`ifdef JTDD_ROMSLOT_CACHE_EN
    localparam int NE = 2;
`else
    localparam int NE = 1;
`endif

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        WAIT_ACK  = 2'd1,
        WAIT_DATA = 2'd2
    } state_t;

    state_t        state_q, state_d;
    logic [NE-1:0] valid_q, valid_d;
    logic [AW-1:0] tag_q  [NE];
    logic [AW-1:0] tag_d  [NE];
    logic [DW-1:0] data_q [NE];
    logic [DW-1:0] data_d [NE];
    logic [AW-1:0] req_addr_q, req_addr_d;
    logic [21:0]   sdram_addr_q, sdram_addr_d;
    logic          sdram_req_q, sdram_req_d;

    logic          hit;
    logic [DW-1:0] hit_data;
    logic          fill;
    logic [NE-1:0] victim_sel;

`ifdef JTDD_ROMSLOT_CACHE_EN
    logic ptr_q, ptr_d;

    always_comb begin
        victim_sel = ptr_q ? 2'b10 : 2'b01;
        ptr_d      = fill ? ~ptr_q : ptr_q;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) ptr_q <= 1'b0;
        else     ptr_q <= ptr_d;
    end
`else
    assign victim_sel = '1;
`endif

    // Lowest matching entry wins; a fill only happens after a miss, so duplicates do not arise.
    always_comb begin
        hit      = 1'b0;
        hit_data = '0;
        for (int unsigned i = 0; i < NE; i++) begin
            if (!hit && valid_q[i] && tag_q[i] == addr) begin
                hit      = 1'b1;
                hit_data = data_q[i];
            end
        end
    end

    assign ok         = addr_ok && hit && !clr;
    assign dout       = hit_data;
    assign sdram_addr = sdram_addr_q;
    assign sdram_req  = sdram_req_q;

    always_comb begin
        state_d      = state_q;
        valid_d      = clr ? '0 : valid_q;
        tag_d        = tag_q;
        data_d       = data_q;
        req_addr_d   = req_addr_q;
        sdram_addr_d = sdram_addr_q;
        sdram_req_d  = sdram_req_q;
        fill         = 1'b0;

        case (state_q)
            IDLE: begin
                if (addr_ok && !hit && !clr) begin
                    req_addr_d   = addr;
                    sdram_addr_d = OFFSET + 22'(addr);
                    sdram_req_d  = 1'b1;
                    state_d      = WAIT_ACK;
                end
            end
            WAIT_ACK: begin
                // Data may arrive together with the ack; store it and skip WAIT_DATA.
                if (sdram_ack) begin
                    sdram_req_d = 1'b0;
                    if (data_dst && data_rdy) begin
                        fill    = 1'b1;
                        state_d = IDLE;
                    end else begin
                        state_d = WAIT_DATA;
                    end
                end
            end
            WAIT_DATA: begin
                if (data_dst && data_rdy) begin
                    fill    = 1'b1;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        // Applied after the clr default so a coinciding fill keeps its entry valid.
        if (fill) begin
            for (int unsigned i = 0; i < NE; i++) begin
                if (victim_sel[i]) begin
                    valid_d[i] = 1'b1;
                    tag_d[i]   = req_addr_q;
                    data_d[i]  = data_read;
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= IDLE;
            valid_q      <= '0;
            tag_q        <= '{default: '0};
            data_q       <= '{default: '0};
            req_addr_q   <= '0;
            sdram_addr_q <= '0;
            sdram_req_q  <= 1'b0;
        end else begin
            state_q      <= state_d;
            valid_q      <= valid_d;
            tag_q        <= tag_d;
            data_q       <= data_d;
            req_addr_q   <= req_addr_d;
            sdram_addr_q <= sdram_addr_d;
            sdram_req_q  <= sdram_req_d;
        end
    end

endmodule

// File: tb/tb_jtdd_gfx_romslot.sv
// Directed bench for jtdd_gfx_romslot; OFFSET near the top of the 22-bit space so sdram_addr wraps.
module tb_jtdd_gfx_romslot;

    localparam int          AW  = 17;
    localparam int          DW  = 16;
    localparam logic [21:0] OFF = 22'h3FFFF8;

    logic          clk = 1'b0;
    logic          rst;
    logic [AW-1:0] addr;
    logic          addr_ok;
    logic          clr;
    logic [DW-1:0] dout;
    logic          ok;
    logic [21:0]   sdram_addr;
    logic          sdram_req;
    logic          sdram_ack;
    logic          data_dst;
    logic          data_rdy;
    logic [DW-1:0] data_read;

    int n_tests = 0;
    int n_fail  = 0;
    int req_rises = 0;
    int r0;
    logic req_prev = 1'b0;

    jtdd_gfx_romslot #(
        .AW    (AW),
        .DW    (DW),
        .OFFSET(OFF)
    ) u_dut (
        .clk       (clk),
        .rst       (rst),
        .addr      (addr),
        .addr_ok   (addr_ok),
        .clr       (clr),
        .dout      (dout),
        .ok        (ok),
        .sdram_addr(sdram_addr),
        .sdram_req (sdram_req),
        .sdram_ack (sdram_ack),
        .data_dst  (data_dst),
        .data_rdy  (data_rdy),
        .data_read (data_read)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (sdram_req && !req_prev) req_rises++;
        req_prev = sdram_req;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Presents a missing address from IDLE and checks the request raised one edge later.
    task automatic start_miss(input logic [AW-1:0] a, input logic [21:0] exp_sa);
        addr = a;
        #1;
        check("miss_ok", 32'(ok), 32'd0);
        step();
        check("req_up", 32'(sdram_req), 32'd1);
        check("req_addr", 32'(sdram_addr), 32'(exp_sa));
    endtask

    // Completes a fetch from WAIT_ACK: ack, then one dst+rdy beat.
    task automatic finish_fetch(input logic [DW-1:0] d);
        sdram_ack = 1'b1;
        step();
        sdram_ack = 1'b0;
        #1;
        check("req_drop", 32'(sdram_req), 32'd0);
        data_dst  = 1'b1;
        data_rdy  = 1'b1;
        data_read = d;
        step();
        data_dst  = 1'b0;
        data_rdy  = 1'b0;
        data_read = '0;
        #1;
    endtask

    initial begin
        rst       = 1'b1;
        addr      = '0;
        addr_ok   = 1'b1;
        clr       = 1'b0;
        sdram_ack = 1'b0;
        data_dst  = 1'b0;
        data_rdy  = 1'b0;
        data_read = '0;
        step();
        step();
        check("rst_ok", 32'(ok), 32'd0);
        check("rst_dout", 32'(dout), 32'd0);
        check("rst_req", 32'(sdram_req), 32'd0);
        check("rst_sa", 32'(sdram_addr), 32'd0);
        rst = 1'b0;

        // Cold miss with the cycle-by-cycle handshake
        start_miss(17'h00010, 22'h000008);
        step();
        check("req_hold", 32'(sdram_req), 32'd1);
        check("sa_hold", 32'(sdram_addr), 32'h000008);
        sdram_ack = 1'b1;
        step();
        sdram_ack = 1'b0;
        #1;
        check("cold_req_drop", 32'(sdram_req), 32'd0);
        step();
        step();
        data_dst  = 1'b1;
        data_rdy  = 1'b1;
        data_read = 16'hA5C3;
        #1;
        check("cold_ok_pre", 32'(ok), 32'd0);
        step();
        data_dst = 1'b0;
        data_rdy = 1'b0;
        #1;
        check("cold_ok", 32'(ok), 32'd1);
        check("cold_dout", 32'(dout), 32'hA5C3);

        // Sustained hit
        for (int i = 0; i < 3; i++) begin
            step();
            check("hit_ok", 32'(ok), 32'd1);
            check("hit_req", 32'(sdram_req), 32'd0);
        end
        addr = 17'h00011;
        #1;
        check("sw_ok", 32'(ok), 32'd0);
        check("sw_dout", 32'(dout), 32'd0);
        step();
        check("sw_req", 32'(sdram_req), 32'd1);
        check("sw_sa", 32'(sdram_addr), 32'h000009);
        finish_fetch(16'h1111);
        check("sw_fill_ok", 32'(ok), 32'd1);
        check("sw_fill_dout", 32'(dout), 32'h1111);
`ifndef JTDD_ROMSLOT_CACHE_EN
        addr = 17'h00010;
        #1;
        check("single_evict", 32'(ok), 32'd0);
`endif

        // Address changes mid-fetch
        start_miss(17'h00100, 22'h0000F8);
        addr = 17'h00200;
        #1;
        check("mid_ok", 32'(ok), 32'd0);
        finish_fetch(16'hBEEF);
        check("mid_old_ok", 32'(ok), 32'd0);
        check("mid_idle_req", 32'(sdram_req), 32'd0);
        addr = 17'h00100;
        #1;
        check("mid_old_hit", 32'(ok), 32'd1);
        check("mid_old_dout", 32'(dout), 32'hBEEF);
        addr = 17'h00200;
        #1;
        check("mid_new_miss", 32'(ok), 32'd0);
        step();
        check("mid2_req", 32'(sdram_req), 32'd1);
        check("mid2_sa", 32'(sdram_addr), 32'h0001F8);
        finish_fetch(16'hCAFE);
        check("mid2_ok", 32'(ok), 32'd1);
        check("mid2_dout", 32'(dout), 32'hCAFE);

        // Same-cycle ack + dst + rdy
        r0 = req_rises;
        start_miss(17'h00300, 22'h0002F8);
        sdram_ack = 1'b1;
        data_dst  = 1'b1;
        data_rdy  = 1'b1;
        data_read = 16'h1234;
        step();
        sdram_ack = 1'b0;
        data_dst  = 1'b0;
        data_rdy  = 1'b0;
        #1;
        check("same_req", 32'(sdram_req), 32'd0);
        check("same_ok", 32'(ok), 32'd1);
        check("same_dout", 32'(dout), 32'h1234);
        step();
        step();
        check("same_req_later", 32'(sdram_req), 32'd0);
        check("same_pulses", 32'(req_rises - r0), 32'd1);

        // clr invalidates; rdy without dst ignored
        start_miss(17'h00010, 22'h000008);
        finish_fetch(16'hA5C3);
        check("clr_pre_ok", 32'(ok), 32'd1);
        clr = 1'b1;
        #1;
        check("clr_ok", 32'(ok), 32'd0);
        check("clr_req", 32'(sdram_req), 32'd0);
        step();
        clr = 1'b0;
        #1;
        check("clr_after_ok", 32'(ok), 32'd0);
        check("clr_after_req", 32'(sdram_req), 32'd0);
        step();
        check("clr_refetch", 32'(sdram_req), 32'd1);
        check("clr_refetch_sa", 32'(sdram_addr), 32'h000008);
        sdram_ack = 1'b1;
        step();
        sdram_ack = 1'b0;
        data_rdy  = 1'b1;
        data_read = 16'hDEAD;
        step();
        data_rdy = 1'b0;
        #1;
        check("nodst_ok", 32'(ok), 32'd0);
        check("nodst_req", 32'(sdram_req), 32'd0);
        step();
        check("nodst_wait", 32'(ok), 32'd0);
        data_dst  = 1'b1;
        data_rdy  = 1'b1;
        data_read = 16'h5A5A;
        step();
        data_dst = 1'b0;
        data_rdy = 1'b0;
        #1;
        check("clr_fill_ok", 32'(ok), 32'd1);
        check("clr_fill_dout", 32'(dout), 32'h5A5A);

        // clr coinciding with the fill write: the write wins
        start_miss(17'h00400, 22'h0003F8);
        sdram_ack = 1'b1;
        step();
        sdram_ack = 1'b0;
        data_dst  = 1'b1;
        data_rdy  = 1'b1;
        data_read = 16'h7777;
        clr       = 1'b1;
        #1;
        check("clrw_ok_during", 32'(ok), 32'd0);
        step();
        data_dst = 1'b0;
        data_rdy = 1'b0;
        clr      = 1'b0;
        #1;
        check("clrw_ok", 32'(ok), 32'd1);
        check("clrw_dout", 32'(dout), 32'h7777);

        // addr_ok falls mid-fetch
        start_miss(17'h00500, 22'h0004F8);
        addr_ok = 1'b0;
        #1;
        check("aok_ok", 32'(ok), 32'd0);
        finish_fetch(16'h0F0F);
        check("aok_ok_after", 32'(ok), 32'd0);
        step();
        check("aok_no_req", 32'(sdram_req), 32'd0);
        addr_ok = 1'b1;
        #1;
        check("aok_hit", 32'(ok), 32'd1);
        check("aok_dout", 32'(dout), 32'h0F0F);
        step();
        check("aok_hit_req", 32'(sdram_req), 32'd0);

`ifdef JTDD_ROMSLOT_CACHE_EN
        // Two-entry store with round-robin victim from a fresh reset
        rst = 1'b1;
        #1;
        rst = 1'b0;
        step();
        start_miss(17'h00020, 22'h000018);
        finish_fetch(16'h2020);
        start_miss(17'h00021, 22'h000019);
        finish_fetch(16'h2121);
        r0 = req_rises;
        for (int i = 0; i < 6; i++) begin
            addr = (i % 2 == 0) ? 17'h00020 : 17'h00021;
            #1;
            check("alt_ok", 32'(ok), 32'd1);
            check("alt_dout", 32'(dout), (i % 2 == 0) ? 32'h2020 : 32'h2121);
            check("alt_req", 32'(sdram_req), 32'd0);
            step();
        end
        check("alt_pulses", 32'(req_rises - r0), 32'd0);
        start_miss(17'h00022, 22'h00001A);
        finish_fetch(16'h2222);
        check("rr_new", 32'(dout), 32'h2222);
        addr = 17'h00020;
        #1;
        check("rr_evicted", 32'(ok), 32'd0);
        addr = 17'h00021;
        #1;
        check("rr_kept", 32'(ok), 32'd1);
        check("rr_kept_dout", 32'(dout), 32'h2121);
        step();
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/jtdd_gfx_romslot.md
Name: jtdd_gfx_romslot

Overview:
- Responder side of the graphics ROM fetch interface used by the tile/scroll layers.
- Accepts a word address plus request-enable from a layer and returns 16-bit data with a valid flag.
- Serves hits from a local tag/data store; misses go to the SDRAM controller over its req/ack/dst/rdy handshake.
- One instance per graphics layer, between the layer and the SDRAM arbiter.

Parameters:
- AW, 17, client word-address width.
- DW, 16, data width.
- OFFSET, 22'h0, SDRAM word base address of this layer's ROM region.

Ports:
- clk  in  1  system clock.
- rst  in  1  reset; asynchronous, active-high.
- addr  in  AW  client word address.
- addr_ok  in  1  client request enable; addr is valid while high.
- clr  in  1  invalidate all stored entries.
- dout  out  DW  data for addr.
- ok  out  1  dout is valid for the current addr.
- sdram_addr  out  22  SDRAM word address.
- sdram_req  out  1  fetch request.
- sdram_ack  in  1  controller accepted the request.
- data_dst  in  1  current SDRAM read data belongs to this slot.
- data_rdy  in  1  SDRAM read data strobe.
- data_read  in  DW  SDRAM read data.

Behaviour:
Reset (async, rst=1):
- state=IDLE; all valid bits=0; sdram_req=0; sdram_addr=0; tags and data=0.
- ok=0 and dout=0 follow from the cleared store.

Hit logic (combinational):
- hit = any entry with valid=1 and tag==addr.
- ok = addr_ok && hit && !clr.
- dout = data of the hit entry, else 0.
- Zero-latency on a hit, so the layer can sample data on its own pixel enable.

FSM:
- IDLE:
  - If addr_ok && !hit && !clr: latch req_addr=addr.
  - Next edge: sdram_addr = OFFSET + zero-extended addr, sdram_req=1, go to WAIT_ACK.
- WAIT_ACK:
  - Hold sdram_req=1 and sdram_addr stable until sdram_ack.
  - On sdram_ack: sdram_req=0, go to WAIT_DATA.
- WAIT_DATA:
  - On data_dst && data_rdy: write data_read into the victim entry, tag=req_addr, valid=1, go to IDLE.
  - ok rises the cycle after data_rdy if addr is unchanged.
  - data_rdy without data_dst is ignored; stay in WAIT_DATA.

Arithmetic and latency:
- sdram_addr is 22 bits, computed modulo 2^22.
- Minimum miss latency: 1 cycle to raise sdram_req + ack wait + data wait + 1 cycle to ok.

Boundary conditions:
- sdram_ack, data_dst and data_rdy high in the same cycle while in WAIT_ACK: drop req, store the data, return to IDLE.
- addr changes mid-fetch: no abort. The fetch completes and stores the old address; the new address is evaluated in IDLE the next cycle.
- addr_ok falls mid-fetch: the fetch completes and is stored; ok stays 0 while addr_ok=0.
- clr in any state: clears all valid bits that cycle.
  - A fetch in flight still completes and its write sets valid.
  - If clr and the data write coincide, the write wins for that entry.
- At most one outstanding SDRAM request.
- sdram_req never reasserts in the same cycle the slot leaves WAIT_DATA.

Optional Feature:
- Macro: JTDD_ROMSLOT_CACHE_EN.
- Defined:
  - Two entries; hit checks both tags.
  - Victim = round-robin pointer that toggles after each fill; pointer resets to 0.
  - Serves the two alternating addresses of a flipped or split tile row without refetch.
- Undefined:
  - Single entry; every fill overwrites it; no pointer logic.

Test Plan:
- Reset then cold miss: rst pulse, addr=17'h00010, addr_ok=1 → next cycle sdram_req=1, sdram_addr=OFFSET+22'h10. ack at cycle 3; data_dst+data_rdy with 16'hA5C3 at cycle 6 → ok=1, dout=16'hA5C3 at cycle 7.
- Hit: hold addr=17'h00010 → ok=1 and sdram_req=0 every cycle. Switch to 17'h00011 → ok=0 the same cycle, sdram_req=1 the next.
- Address change mid-fetch: issue miss for 17'h00100, change to 17'h00200 before ack → 17'h00100 fetch stored, then second request with sdram_addr=OFFSET+22'h200. ok only after the second rdy.
- Same-cycle ack+rdy with data_dst: data 16'h1234 → state IDLE next cycle, ok=1, exactly one req pulse.
- clr: after a hit on 17'h00010, pulse clr → ok=0 during clr, then a new sdram_req for 17'h00010. A data_rdy without data_dst meanwhile is ignored.
- JTDD_ROMSLOT_CACHE_EN: fill 17'h00020 then 17'h00021, alternate addr each cycle → ok=1 continuously, no sdram_req. Fill 17'h00022 → replaces the 17'h00020 entry (pointer=0).
